// File: rtl/rv_lsu_handshake.sv
// Multi-cycle load/store unit: classifies core requests, drives a req/gnt/rvalid data bus
// with lane-shifted strobes and data, and returns extended load data or an error cause.
module rv_lsu_handshake #(
    parameter int unsigned XLEN           = 32,
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [2:0]          req_funct3,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [XLEN-1:0]     req_wdata,
    output logic                rsp_valid,
    output logic [XLEN-1:0]     rsp_rdata,
    output logic [1:0]          rsp_cause,
    output logic                bus_req,
    output logic                bus_we,
    output logic [ADDR_W-1:0]   bus_addr,
    output logic [XLEN-1:0]     bus_wdata,
    output logic [XLEN/8-1:0]   bus_strobe,
    input  logic                bus_gnt,
    input  logic                bus_rvalid,
    input  logic [XLEN-1:0]     bus_rdata
);

    localparam int unsigned NB    = XLEN / 8;
    localparam int unsigned OFF_W = $clog2(NB);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] REQ    = 2'd1;
    localparam logic [1:0] WAIT_R = 2'd2;
    localparam logic [1:0] RESP   = 2'd3;

    localparam logic [1:0] CAUSE_OK       = 2'b00;
    localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
    localparam logic [1:0] CAUSE_ILLEGAL  = 2'b10;
    localparam logic [1:0] CAUSE_TIMEOUT  = 2'b11;

    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [1:0]        state_q, state_d;
    logic [15:0]       cnt_q, cnt_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [OFF_W-1:0]  off_q, off_d;
    logic              req_ready_q, rsp_valid_q;
    logic [XLEN-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic [1:0]        rsp_cause_q, rsp_cause_d;
    logic              bus_req_q, bus_req_d, bus_we_q, bus_we_d;
    logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
    logic [XLEN-1:0]   bus_wdata_q, bus_wdata_d;
    logic [NB-1:0]     bus_strobe_q, bus_strobe_d;

    logic [OFF_W-1:0]  req_off;
    logic              illegal, misaligned, expire;
    logic [NB-1:0]     strobe_new;
    logic [XLEN-1:0]   wdata_new, lane, load_data;

    assign req_off = req_addr[OFF_W-1:0];
    assign expire  = (cnt_q == CNT_LAST);

    always_comb begin
        if (req_we) begin
            illegal = req_funct3[2] || (XLEN == 32 && req_funct3 == 3'b011);
        end else begin
            illegal = (req_funct3 == 3'b111) ||
                      (XLEN == 32 && (req_funct3 == 3'b011 || req_funct3 == 3'b110));
        end
        unique case (req_funct3[1:0])
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = req_addr[0];
            2'b10:   misaligned = |req_addr[1:0];
            default: misaligned = |req_addr[2:0];
        endcase
    end

    // Store data is replicated into every lane so the strobe alone selects the bytes.
    always_comb begin
        unique case (req_funct3[1:0])
            2'b00: begin
                strobe_new = NB'(1) << req_off;
                wdata_new  = {NB{req_wdata[7:0]}};
            end
            2'b01: begin
                strobe_new = NB'(3) << req_off;
                wdata_new  = {(NB/2){req_wdata[15:0]}};
            end
            2'b10: begin
                strobe_new = NB'(15) << req_off;
                wdata_new  = {(NB/4){req_wdata[31:0]}};
            end
            default: begin
                strobe_new = '1;
                wdata_new  = req_wdata;
            end
        endcase
    end

    always_comb begin
        lane = bus_rdata >> {off_q, 3'b000};
        case (funct3_q)
            3'b000:  load_data = XLEN'($signed(lane[7:0]));
            3'b001:  load_data = XLEN'($signed(lane[15:0]));
            3'b010:  load_data = XLEN'($signed(lane[31:0]));
            3'b100:  load_data = XLEN'(lane[7:0]);
            3'b101:  load_data = XLEN'(lane[15:0]);
            3'b110:  load_data = XLEN'(lane[31:0]);
            default: load_data = lane;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        funct3_d     = funct3_q;
        off_d        = off_q;
        rsp_rdata_d  = rsp_rdata_q;
        rsp_cause_d  = rsp_cause_q;
        bus_req_d    = bus_req_q;
        bus_we_d     = bus_we_q;
        bus_addr_d   = bus_addr_q;
        bus_wdata_d  = bus_wdata_q;
        bus_strobe_d = bus_strobe_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    funct3_d = req_funct3;
                    off_d    = req_off;
                    cnt_d    = '0;
                    if (illegal || misaligned) begin
                        state_d     = RESP;
                        rsp_cause_d = illegal ? CAUSE_ILLEGAL : CAUSE_MISALIGN;
                        rsp_rdata_d = '0;
                    end else begin
                        state_d      = REQ;
                        bus_req_d    = 1'b1;
                        bus_we_d     = req_we;
                        bus_addr_d   = {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                        bus_wdata_d  = req_we ? wdata_new : '0;
                        bus_strobe_d = req_we ? strobe_new : '0;
                    end
                end
            end
            REQ: begin
                cnt_d = cnt_q + 16'd1;
                // Completion beats expiry in the same cycle.
                if (bus_gnt && (bus_we_q || bus_rvalid)) begin
                    state_d     = RESP;
                    bus_req_d   = 1'b0;
                    rsp_cause_d = CAUSE_OK;
                    rsp_rdata_d = bus_we_q ? '0 : load_data;
                end else if (expire) begin
                    state_d     = RESP;
                    bus_req_d   = 1'b0;
                    rsp_cause_d = CAUSE_TIMEOUT;
                    rsp_rdata_d = '0;
                end else if (bus_gnt) begin
                    state_d   = WAIT_R;
                    bus_req_d = 1'b0;
                end
            end
            WAIT_R: begin
                cnt_d = cnt_q + 16'd1;
                if (bus_rvalid) begin
                    state_d     = RESP;
                    rsp_cause_d = CAUSE_OK;
                    rsp_rdata_d = load_data;
                end else if (expire) begin
                    state_d     = RESP;
                    rsp_cause_d = CAUSE_TIMEOUT;
                    rsp_rdata_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            funct3_q     <= '0;
            off_q        <= '0;
            req_ready_q  <= 1'b1;
            rsp_valid_q  <= 1'b0;
            rsp_rdata_q  <= '0;
            rsp_cause_q  <= '0;
            bus_req_q    <= 1'b0;
            bus_we_q     <= 1'b0;
            bus_addr_q   <= '0;
            bus_wdata_q  <= '0;
            bus_strobe_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            funct3_q     <= funct3_d;
            off_q        <= off_d;
            req_ready_q  <= (state_d == IDLE);
            rsp_valid_q  <= (state_d == RESP);
            rsp_rdata_q  <= rsp_rdata_d;
            rsp_cause_q  <= rsp_cause_d;
            bus_req_q    <= bus_req_d;
            bus_we_q     <= bus_we_d;
            bus_addr_q   <= bus_addr_d;
            bus_wdata_q  <= bus_wdata_d;
            bus_strobe_q <= bus_strobe_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_rdata  = rsp_rdata_q;
    assign rsp_cause  = rsp_cause_q;
    assign bus_req    = bus_req_q;
    assign bus_we     = bus_we_q;
    assign bus_addr   = bus_addr_q;
    assign bus_wdata  = bus_wdata_q;
    assign bus_strobe = bus_strobe_q;

endmodule

// File: tb/tb_rv_lsu_handshake.sv
// Bench for rv_lsu_handshake: a 32-bit instance (short timeout) driven by random and directed
// accesses against a behavioural model, plus a 64-bit instance for LWU/SD/LD lanes.
module tb_rv_lsu_handshake;

    localparam int TO = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic        req_valid, req_ready, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_cause;
    logic        bus_req, bus_we, bus_gnt, bus_rvalid;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic [3:0]  bus_strobe;

    logic        req_valid_w, req_ready_w, req_we_w;
    logic [2:0]  req_funct3_w;
    logic [31:0] req_addr_w, bus_addr_w;
    logic [63:0] req_wdata_w, rsp_rdata_w, bus_wdata_w, bus_rdata_w;
    logic        rsp_valid_w, bus_req_w, bus_we_w, bus_gnt_w, bus_rvalid_w;
    logic [1:0]  rsp_cause_w;
    logic [7:0]  bus_strobe_w;

    int checks = 0;
    int errors = 0;

    rv_lsu_handshake #(.XLEN(32), .ADDR_W(32), .TIMEOUT_CYCLES(TO)) u_dut32 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_cause(rsp_cause),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_strobe(bus_strobe), .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid),
        .bus_rdata(bus_rdata)
    );

    rv_lsu_handshake #(.XLEN(64), .ADDR_W(32), .TIMEOUT_CYCLES(8)) u_dut64 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid_w), .req_ready(req_ready_w), .req_we(req_we_w),
        .req_funct3(req_funct3_w), .req_addr(req_addr_w), .req_wdata(req_wdata_w),
        .rsp_valid(rsp_valid_w), .rsp_rdata(rsp_rdata_w), .rsp_cause(rsp_cause_w),
        .bus_req(bus_req_w), .bus_we(bus_we_w), .bus_addr(bus_addr_w),
        .bus_wdata(bus_wdata_w), .bus_strobe(bus_strobe_w), .bus_gnt(bus_gnt_w),
        .bus_rvalid(bus_rvalid_w), .bus_rdata(bus_rdata_w)
    );

    // Reference model for the 32-bit instance.
    function automatic logic [1:0] model_cause(input logic we, input logic [2:0] f3,
                                               input logic [31:0] addr);
        bit legal;
        int nbytes;
        if (we) legal = (f3 <= 3'd2);
        else legal = (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        if (!legal) return 2'd2;
        nbytes = 1 << f3[1:0];
        if ((addr % nbytes) != 0) return 2'd1;
        return 2'd0;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr,
                                               input logic [31:0] rdata);
        longint v, m;
        int nbytes;
        nbytes = 1 << f3[1:0];
        v = longint'(rdata >> (8 * (addr % 4)));
        m = (longint'(1) << (8 * nbytes)) - 1;
        v = v & m;
        if (!f3[2] && v > m / 2) v = v - (m + 1);
        return v[31:0];
    endfunction

    function automatic logic [3:0] model_strobe(input logic [2:0] f3, input logic [31:0] addr);
        int nbytes;
        nbytes = 1 << f3[1:0];
        return 4'(((1 << nbytes) - 1) << (addr % 4));
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] wdata);
        logic [31:0] r;
        int nbytes;
        nbytes = 1 << f3[1:0];
        for (int k = 0; k < 4; k++) r[8*k +: 8] = wdata[8*(k % nbytes) +: 8];
        return r;
    endfunction

    // One access on the 32-bit DUT; gnt arrives gnt_dly cycles into the bus phase and rvalid
    // rv_dly cycles after that. Entered and left at posedge+1 with the DUT idle.
    task automatic run_txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] rdata,
                           input int gnt_dly, input int rv_dly);
        logic [1:0]  exp_cause;
        logic [31:0] exp_rdata;
        int c, resp_i;
        bit done, exp_req;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++; $display("FAIL ready_idle: got %b want 1", req_ready);
        end
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
        @(posedge clk); #1;
        req_valid = 1'b0;
        exp_cause = model_cause(we, f3, addr);
        exp_rdata = '0;
        if (exp_cause != 2'd0) begin
            checks++;
            if (rsp_valid !== 1'b1 || rsp_cause !== exp_cause || rsp_rdata !== 32'd0 ||
                bus_req !== 1'b0) begin
                errors++;
                $display("FAIL err_rsp f3=%0d addr=%h: valid=%b cause=%0d rdata=%h bus_req=%b want 1 %0d 0 0",
                         f3, addr, rsp_valid, rsp_cause, rsp_rdata, bus_req, exp_cause);
            end
        end else begin
            c = we ? gnt_dly : gnt_dly + rv_dly;
            done = (c <= TO - 1);
            resp_i = done ? c + 1 : TO;
            if (!done) exp_cause = 2'd3;
            else if (!we) exp_rdata = model_load(f3, addr, rdata);
            checks++;
            if (bus_addr !== (addr & ~32'd3) || bus_we !== we ||
                (we && (bus_strobe !== model_strobe(f3, addr) ||
                        bus_wdata !== model_wdata(f3, wdata)))) begin
                errors++;
                $display("FAIL bus_fields addr=%h: addr=%h we=%b strb=%b wdata=%h want %h %b %b %h",
                         addr, bus_addr, bus_we, bus_strobe, bus_wdata, addr & ~32'd3, we,
                         model_strobe(f3, addr), model_wdata(f3, wdata));
            end
            for (int i = 0; i <= resp_i; i++) begin
                exp_req = (i < resp_i) && (i <= gnt_dly);
                checks++;
                if (bus_req !== exp_req || rsp_valid !== (i == resp_i)) begin
                    errors++;
                    $display("FAIL cycle%0d addr=%h: bus_req=%b rsp_valid=%b want %b %b",
                             i, addr, bus_req, rsp_valid, exp_req, i == resp_i);
                end
                if (i == resp_i) begin
                    checks++;
                    if (rsp_cause !== exp_cause || rsp_rdata !== exp_rdata) begin
                        errors++;
                        $display("FAIL rsp f3=%0d addr=%h: cause=%0d rdata=%h want %0d %h",
                                 f3, addr, rsp_cause, rsp_rdata, exp_cause, exp_rdata);
                    end
                end
                bus_gnt = (i == gnt_dly);
                bus_rvalid = !we && (i == gnt_dly + rv_dly);
                bus_rdata = bus_rvalid ? rdata : $urandom;
                @(posedge clk); #1;
            end
            bus_gnt = 1'b0; bus_rvalid = 1'b0;
        end
        if (exp_cause != 2'd0 && model_cause(we, f3, addr) != 2'd0) begin
            @(posedge clk); #1;
        end
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || rsp_cause !== exp_cause ||
            rsp_rdata !== exp_rdata) begin
            errors++;
            $display("FAIL after_rsp: valid=%b ready=%b cause=%0d rdata=%h want 0 1 %0d %h",
                     rsp_valid, req_ready, rsp_cause, rsp_rdata, exp_cause, exp_rdata);
        end
    endtask

    task automatic test_reset;
        #1 rst_n = 1'b0;
        #2;
        checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_rdata !== '0 || rsp_cause !== '0 ||
            bus_req !== 1'b0 || bus_we !== 1'b0 || bus_addr !== '0 || bus_wdata !== '0 ||
            bus_strobe !== '0) begin
            errors++;
            $display("FAIL reset32: ready=%b valid=%b rdata=%h cause=%0d req=%b we=%b addr=%h wd=%h strb=%b",
                     req_ready, rsp_valid, rsp_rdata, rsp_cause, bus_req, bus_we, bus_addr,
                     bus_wdata, bus_strobe);
        end
        checks++;
        if (req_ready_w !== 1'b1 || rsp_valid_w !== 1'b0 || bus_req_w !== 1'b0 ||
            bus_strobe_w !== '0 || rsp_rdata_w !== '0) begin
            errors++;
            $display("FAIL reset64: ready=%b valid=%b req=%b strb=%b rdata=%h",
                     req_ready_w, rsp_valid_w, bus_req_w, bus_strobe_w, rsp_rdata_w);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_store_lanes;
        run_txn(1'b1, 3'b000, 32'h103, 32'h0000_00A5, 32'h0, 0, 0);
        run_txn(1'b1, 3'b001, 32'h202, 32'h1234_BEEF, 32'h0, 2, 0);
        run_txn(1'b1, 3'b010, 32'h300, 32'hCAFE_F00D, 32'h0, 3, 0);
        run_txn(1'b1, 3'b000, 32'h101, 32'h0000_005C, 32'h0, 1, 0);
    endtask

    task automatic test_load_extend;
        run_txn(1'b0, 3'b000, 32'h102, 32'h0, 32'h12F0_5678, 0, 3);
        run_txn(1'b0, 3'b100, 32'h102, 32'h0, 32'h12F0_5678, 0, 3);
        run_txn(1'b0, 3'b001, 32'h102, 32'h0, 32'h8001_7FFF, 1, 0);
        run_txn(1'b0, 3'b101, 32'h102, 32'h0, 32'h8001_7FFF, 0, 1);
        run_txn(1'b0, 3'b010, 32'h104, 32'h0, 32'h8765_4321, 0, 0);
    endtask

    task automatic test_errors;
        run_txn(1'b0, 3'b010, 32'h102, 32'h0, 32'h0, 0, 0);
        run_txn(1'b0, 3'b111, 32'h100, 32'h0, 32'h0, 0, 0);
        run_txn(1'b0, 3'b011, 32'h100, 32'h0, 32'h0, 0, 0);
        run_txn(1'b1, 3'b100, 32'h100, 32'h1, 32'h0, 0, 0);
        run_txn(1'b1, 3'b010, 32'h101, 32'h1, 32'h0, 0, 0);
    endtask

    task automatic test_timeout;
        run_txn(1'b0, 3'b010, 32'h400, 32'h0, 32'h1111_2222, 100, 0);
        for (int i = 0; i < 2; i++) begin
            bus_gnt = 1'b1; bus_rvalid = 1'b1; bus_rdata = 32'hDEAD_BEEF;
            @(posedge clk); #1;
            checks++;
            if (rsp_valid !== 1'b0 || bus_req !== 1'b0 || req_ready !== 1'b1) begin
                errors++;
                $display("FAIL stray%0d: valid=%b req=%b ready=%b want 0 0 1",
                         i, rsp_valid, bus_req, req_ready);
            end
        end
        bus_gnt = 1'b0; bus_rvalid = 1'b0;
        run_txn(1'b0, 3'b010, 32'h404, 32'h0, 32'h0BAD_F00D, 0, 1);
        run_txn(1'b0, 3'b000, 32'h405, 32'h0, 32'h0000_8000, 2, 2);
        run_txn(1'b1, 3'b010, 32'h408, 32'h5, 32'h0, 3, 0);
        run_txn(1'b1, 3'b010, 32'h40C, 32'h5, 32'h0, 4, 0);
    endtask

    task automatic test_back_to_back;
        for (int n = 0; n < 60; n++) begin
            run_txn(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                    32'h1000 + 32'($urandom_range(0, 15)), $urandom, $urandom,
                    $urandom_range(0, 4), $urandom_range(0, 3));
        end
    endtask

    task automatic test_reset_mid;
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h200;
        @(posedge clk); #1;
        req_valid = 1'b0;
        bus_gnt = 1'b1;
        @(posedge clk); #1;
        bus_gnt = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_rdata !== '0 || rsp_cause !== '0 ||
            bus_req !== 1'b0 || bus_addr !== '0 || bus_strobe !== '0 || bus_wdata !== '0) begin
            errors++;
            $display("FAIL reset_mid: ready=%b valid=%b rdata=%h cause=%0d req=%b addr=%h",
                     req_ready, rsp_valid, rsp_rdata, rsp_cause, bus_req, bus_addr);
        end
        bus_rvalid = 1'b1; bus_rdata = 32'h7777_7777;
        @(posedge clk); #1;
        bus_rvalid = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL post_reset: valid=%b ready=%b want 0 1", rsp_valid, req_ready);
        end
        run_txn(1'b0, 3'b001, 32'h206, 32'h0, 32'hF00F_1234, 0, 0);
    endtask

    task automatic test_xlen64;
        logic [63:0] wd;
        wd = {$urandom, $urandom};
        req_valid_w = 1'b1; req_we_w = 1'b0; req_funct3_w = 3'b110; req_addr_w = 32'h14;
        @(posedge clk); #1;
        req_valid_w = 1'b0;
        checks++;
        if (bus_req_w !== 1'b1 || bus_addr_w !== 32'h10) begin
            errors++;
            $display("FAIL lwu64_bus: req=%b addr=%h want 1 10", bus_req_w, bus_addr_w);
        end
        bus_gnt_w = 1'b1; bus_rvalid_w = 1'b1; bus_rdata_w = 64'h8000_0001_0000_0000;
        @(posedge clk); #1;
        bus_gnt_w = 1'b0; bus_rvalid_w = 1'b0;
        checks++;
        if (rsp_valid_w !== 1'b1 || rsp_cause_w !== 2'd0 ||
            rsp_rdata_w !== 64'h0000_0000_8000_0001) begin
            errors++;
            $display("FAIL lwu64_rsp: valid=%b cause=%0d rdata=%h want 1 0 0000000080000001",
                     rsp_valid_w, rsp_cause_w, rsp_rdata_w);
        end
        @(posedge clk); #1;
        req_valid_w = 1'b1; req_we_w = 1'b1; req_funct3_w = 3'b011; req_addr_w = 32'h8;
        req_wdata_w = wd;
        @(posedge clk); #1;
        req_valid_w = 1'b0;
        checks++;
        if (bus_req_w !== 1'b1 || bus_strobe_w !== 8'hFF || bus_addr_w !== 32'h8 ||
            bus_wdata_w !== wd || bus_we_w !== 1'b1) begin
            errors++;
            $display("FAIL sd64_bus: req=%b strb=%h addr=%h wd=%h we=%b want 1 ff 8 %h 1",
                     bus_req_w, bus_strobe_w, bus_addr_w, bus_wdata_w, bus_we_w, wd);
        end
        bus_gnt_w = 1'b1;
        @(posedge clk); #1;
        bus_gnt_w = 1'b0;
        checks++;
        if (rsp_valid_w !== 1'b1 || rsp_cause_w !== 2'd0 || rsp_rdata_w !== '0) begin
            errors++;
            $display("FAIL sd64_rsp: valid=%b cause=%0d rdata=%h want 1 0 0",
                     rsp_valid_w, rsp_cause_w, rsp_rdata_w);
        end
        @(posedge clk); #1;
        req_valid_w = 1'b1; req_we_w = 1'b0; req_funct3_w = 3'b011; req_addr_w = 32'hC;
        @(posedge clk); #1;
        req_valid_w = 1'b0;
        checks++;
        if (rsp_valid_w !== 1'b1 || rsp_cause_w !== 2'd1 || bus_req_w !== 1'b0) begin
            errors++;
            $display("FAIL ld64_misaligned: valid=%b cause=%0d req=%b want 1 1 0",
                     rsp_valid_w, rsp_cause_w, bus_req_w);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0; req_addr = '0; req_wdata = '0;
        bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;
        req_valid_w = 1'b0; req_we_w = 1'b0; req_funct3_w = '0; req_addr_w = '0;
        req_wdata_w = '0; bus_gnt_w = 1'b0; bus_rvalid_w = 1'b0; bus_rdata_w = '0;
        test_reset();
        test_store_lanes();
        test_load_extend();
        test_errors();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        test_xlen64();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rv_lsu_handshake.md
Name: rv_lsu_handshake

Overview:
Multi-cycle load/store unit for the RV core. It replaces the single-cycle, always-ready data-memory path with a request/grant/response bus that tolerates wait states. It accepts one access at a time from the Execute stage and drives byte strobes and lane-shifted write data. It returns sign- or zero-extended load data, or an error cause for misaligned accesses, illegal funct3 and bus timeouts. It sits between the Execute/WriteBack stages and the data-memory bus.

Parameters:
XLEN, 32, data width; legal values 32 or 64. 64 enables LD/SD/LWU.
ADDR_W, 32, byte-address width.
TIMEOUT_CYCLES, 255, number of cycles waited in REQ+WAIT_R before aborting; range 1..65535.

Ports:
clk  in  1  clock.
rst_n  in  1  reset, asynchronous, active-low.
req_valid  in  1  core requests an access.
req_ready  out  1  LSU can accept; high only in IDLE.
req_we  in  1  1 = store, 0 = load.
req_funct3  in  3  RISC-V load/store funct3.
req_addr  in  ADDR_W  byte address (ALU result).
req_wdata  in  XLEN  store data (rs2).
rsp_valid  out  1  one-cycle completion pulse.
rsp_rdata  out  XLEN  extended load data; 0 for stores and errors.
rsp_cause  out  2  00 ok, 01 misaligned, 10 illegal funct3, 11 timeout.
bus_req  out  1  bus request, held until bus_gnt.
bus_we  out  1  bus write.
bus_addr  out  ADDR_W  address aligned down to XLEN/8.
bus_wdata  out  XLEN  lane-replicated write data.
bus_strobe  out  XLEN/8  byte enables.
bus_gnt  in  1  bus accepts request.
bus_rvalid  in  1  read data valid.
bus_rdata  in  XLEN  read data (full word).

Behaviour:
- Reset (async, rst_n=0): state IDLE. req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_cause=0, bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0, bus_strobe=0, timeout counter=0. Reset mid-transaction abandons it immediately. No response is issued.
- All outputs are registered. req_ready is 1 exactly when state==IDLE.
- FSM states: IDLE, REQ, WAIT_R, RESP.
- IDLE: on req_valid, latch addr, funct3, we, wdata and classify the access:
  - Illegal funct3 → RESP, cause 10. Illegal encodings: loads 011 when XLEN=32, 110 when XLEN=32, 111; stores 011 when XLEN=32, 1xx.
  - Misaligned (H with addr[0]≠0; W with addr[1:0]≠0; D with addr[2:0]≠0) → RESP, cause 01.
  - Neither case drives any bus activity.
  - Otherwise → REQ, with bus_req=1 and bus signals valid in the next cycle; counter cleared.
- Store lane rules (off = addr mod XLEN/8):
  - SB: strobe = 1<<off; wdata = byte replicated across all lanes.
  - SH: strobe = 2'b11<<off; halfword replicated.
  - SW: strobe = 4'hF<<off; word replicated.
  - SD: strobe all ones.
- REQ: bus signals held stable until bus_gnt.
  - Store: gnt → RESP, cause 00.
  - Load: gnt & rvalid in the same cycle → RESP. gnt alone → WAIT_R with bus_req=0.
- WAIT_R: bus_rvalid → RESP.
- Load extraction: select the lane at off. LB/LH/LW sign-extend to XLEN; LBU/LHU/LWU zero-extend. Data is captured on the rvalid cycle.
- Timeout: the counter increments every cycle in REQ or WAIT_R. When it equals TIMEOUT_CYCLES-1 and no completion occurs that cycle → RESP, cause 11, bus_req dropped, rdata 0. Completion in the same cycle as expiry wins, so the cause is 00.
- RESP: rsp_valid=1 for exactly one cycle, then IDLE. rsp_rdata/rsp_cause hold until the next response.
- bus_rvalid or bus_gnt seen in IDLE or RESP (for example, late after a timeout) is ignored.
- Minimum latency, load or store, with gnt at the first opportunity: accept at cycle T, bus_req at T+1, rsp_valid at T+2. Error responses: rsp_valid at T+1.
- Back-to-back: a new request can be accepted the cycle after rsp_valid. Throughput is at most 1 access per 3 cycles.
- bus_req never asserts while rst_n=0 or for a request that classifies as an error.

Test Plan:
- SB addr=0x103, wdata=0x000000A5, gnt immediate → bus_addr=0x100, strobe=4'b1000, bus_wdata=0xA5A5A5A5; rsp_valid at T+2, cause 00.
- LB addr=0x102, bus_rdata=0x12F05678, rvalid 3 cycles after gnt → rsp_rdata=0xFFFFFFF0. Same access as LBU → 0x000000F0.
- LW addr=0x102 → no bus_req; rsp_valid at T+1, cause 01. Load funct3=3'b111 → cause 10.
- TIMEOUT_CYCLES=4, gnt never asserted → bus_req high 4 cycles, then rsp_valid, cause 11, rdata 0. A later stray rvalid is ignored, and the following LW completes normally.
- XLEN=64: LWU addr=0x14, bus_rdata=0x80000001_00000000 → rsp_rdata=0x0000000080000001. SD addr=0x8 → strobe=8'hFF.
- rst_n pulsed low during WAIT_R → all outputs 0 asynchronously, no rsp_valid. After release the next request completes correctly.
